// File: rtl/ha_array_reducer_8x8.sv
// Multi-cycle final adder for the 8x8 approximate multiplier: folds four HA-array rows into a binary product.
// Optional HA_REDUCER_SAT_EN saturates an oversized sum to all ones instead of wrapping.
//
// state | meaning
// IDLE  | ready for a row set; in_valid captures all rows and clears the accumulator
// ACC   | adds one row per cycle (row counter 0..3); the last add registers out_data
// DONE  | out_valid held with stable out_data until out_ready
module ha_array_reducer_8x8 #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int ACC_W = 17;
  localparam int EXT_W = (OUT_W > ACC_W) ? OUT_W + 1 : ACC_W + 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0][8:0]  t_q;
  logic [3:0][6:0]  b_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] row_v;
  logic [ACC_W-1:0] sum;
  logic [1:0]       cnt_q;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] result;
  logic             out_valid_q;
  logic             accept;
  logic             last_row;

  assign accept   = in_valid && (state_q == IDLE);
  assign last_row = (state_q == ACC) && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACC;
      end
      ACC:     if (cnt_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row k: sum bits at 2^(2k+i), carry bits two places higher.
  always_comb begin
    row_v = ACC_W'(t_q[cnt_q]) + (ACC_W'(b_q[cnt_q]) << 2);
    row_v = row_v << {cnt_q, 1'b0};
  end

  assign sum = acc_q + row_v;

`ifdef HA_REDUCER_SAT_EN
  assign result = (EXT_W'(sum) >= (EXT_W'(1) << OUT_W)) ? '1 : OUT_W'(sum);
`else
  assign result = OUT_W'(sum);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        t_q   <= {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
        b_q   <= {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == ACC) begin
        acc_q <= sum;
        cnt_q <= cnt_q + 2'd1;
      end
      if (last_row) begin
        out_q       <= result;
        out_valid_q <= 1'b1;
      end else if ((state_q == DONE) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule
